// File: rtl/lii_rx_fifo_if.sv
// Handshake bundle for the LII receive stage. It carries the phy-side flit
// channel and the kernel-side stream. The FIFO uses the slave view. The
// producer/consumer environment uses the master view.
interface lii_rx_fifo_if #(
    parameter int PW = 64,
    parameter int DW = 8
);
    logic [PW-1:0] lii_in_p0_tdata;
    logic          lii_in_p0_tvalid;
    logic          lii_in_p0_tready;
    logic [7:0]    lii_in_p0_src;
    logic [7:0]    lii_in_p0_dst;

    logic [DW-1:0] k_stream_tdata;
    logic          k_stream_tvalid;
    logic          k_stream_tready;
    logic [7:0]    k_stream_src;

    modport master (
        output lii_in_p0_tdata,
        output lii_in_p0_tvalid,
        input  lii_in_p0_tready,
        output lii_in_p0_src,
        output lii_in_p0_dst,
        input  k_stream_tdata,
        input  k_stream_tvalid,
        output k_stream_tready,
        input  k_stream_src
    );

    modport slave (
        input  lii_in_p0_tdata,
        input  lii_in_p0_tvalid,
        output lii_in_p0_tready,
        input  lii_in_p0_src,
        input  lii_in_p0_dst,
        output k_stream_tdata,
        output k_stream_tvalid,
        input  k_stream_tready,
        output k_stream_src
    );
endinterface

// File: rtl/lii_rx_fifo.sv
// LII receive stage. Flits addressed to LOCAL_ID are buffered in a
// first-word-fall-through FIFO. The source ID is stored next to each payload.
// Flits addressed elsewhere are taken immediately, thrown away, and counted.
module lii_rx_fifo #(
    parameter int        PW       = 64,
    parameter int        DW       = 8,
    parameter int        DEPTH    = 16,
    parameter logic [7:0] LOCAL_ID = 8'h01,
    localparam int       AW       = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          arstn,
    lii_rx_fifo_if.slave  bus,
    output logic [AW:0]   level,
    output logic [15:0]   drop_cnt,
    output logic          trunc_err
);

    localparam int         EW       = 8 + DW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          trunc_err_q, trunc_err_d;

    logic match;
    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic drop_en;
    logic hi_nz;

    assign match = (bus.lii_in_p0_dst == LOCAL_ID);
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // Misrouted flits are never stalled. Only matching flits see a full FIFO.
    // A pop in the same cycle does not free a slot for a write.
    assign bus.lii_in_p0_tready = arstn & (~match | ~full);

    assign wr_en   = bus.lii_in_p0_tvalid & bus.lii_in_p0_tready & match;
    assign drop_en = arstn & bus.lii_in_p0_tvalid & ~match;
    assign rd_en   = ~empty & bus.k_stream_tready;

    // Upper payload bits exist only when the kernel stream is narrower than the phy.
    generate
        if (DW < PW) begin : g_trunc
            assign hi_nz = |bus.lii_in_p0_tdata[PW-1:DW];
        end else begin : g_no_trunc
            assign hi_nz = 1'b0;
        end
    endgenerate

    // Compute next-state values for pointers, occupancy and status.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        drop_cnt_d  = drop_cnt_q;
        trunc_err_d = trunc_err_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (drop_en && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end

        if (wr_en && hi_nz) begin
            trunc_err_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low clear.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_cnt_q  <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    // Store each accepted flit as {src, payload}. The storage is not reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.lii_in_p0_src, bus.lii_in_p0_tdata[DW-1:0]};
        end
    end

    // FWFT head. The head only moves on a pop, so it holds under backpressure.
    assign bus.k_stream_tvalid = ~empty;
    assign {bus.k_stream_src, bus.k_stream_tdata} = mem_q[rd_ptr_q];

    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;
    assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_lii_rx_fifo.sv
// Directed bench for lii_rx_fifo. Inputs change 1 ns after the rising edge,
// and checks are made a further 1 ns later, well away from the next edge.
module tb_lii_rx_fifo;

    localparam int PW    = 64;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          aclk;
    logic          arstn;
    logic [AW:0]   level;
    logic [15:0]   drop_cnt;
    logic          trunc_err;

    int n_chk;
    int n_fail;

    lii_rx_fifo_if #(.PW(PW), .DW(DW)) bus ();

    lii_rx_fifo #(
        .PW(PW), .DW(DW), .DEPTH(DEPTH), .LOCAL_ID(8'h01)
    ) dut (
        .aclk      (aclk),
        .arstn     (arstn),
        .bus       (bus),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .trunc_err (trunc_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] dst, input logic [7:0] src,
                         input logic [63:0] data);
        bus.lii_in_p0_tvalid = v;
        bus.lii_in_p0_dst    = dst;
        bus.lii_in_p0_src    = src;
        bus.lii_in_p0_tdata  = data;
    endtask

    int sent;
    int rcvd;
    int cyc;
    logic in_fire;
    logic out_fire;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        arstn  = 1'b0;
        bus.k_stream_tready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 64'h0);

        // ---- reset state ----
        repeat (2) @(posedge aclk);
        #1;
        drive(1'b1, 8'h01, 8'h05, 64'h11);
        #1;
        chk("rst_tready", bus.lii_in_p0_tready, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_kvalid", bus.k_stream_tvalid, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_trunc", trunc_err, 1'b0);
        tick();
        arstn = 1'b1;

        // ---- basic pass: 4 flits, kernel always ready ----
        bus.k_stream_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] d;
            d = 64'h11 * (i + 1);
            drive(1'b1, 8'h01, 8'h05, d);
            #1;
            chk("basic_tready", bus.lii_in_p0_tready, 1'b1);
            tick();
            chk("basic_kvalid", bus.k_stream_tvalid, 1'b1);
            chk("basic_data", bus.k_stream_tdata, d[7:0]);
            chk("basic_src", bus.k_stream_src, 8'h05);
            chk("basic_level", level, 1);
        end
        drive(1'b0, 8'h01, 8'h05, 64'h0);
        tick();
        chk("basic_level_end", level, 0);
        chk("basic_kvalid_end", bus.k_stream_tvalid, 1'b0);
        chk("basic_drop", drop_cnt, 0);

        // ---- fill / backpressure: 17 flits, kernel stalled ----
        bus.k_stream_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h01, 8'h03, 64'(i));
            #1;
            chk("fill_tready", bus.lii_in_p0_tready, 1'b1);
            tick();
        end
        chk("fill_level16", level, 16);
        drive(1'b1, 8'h01, 8'h03, 64'd16);
        #1;
        chk("fill_tready_full", bus.lii_in_p0_tready, 1'b0);
        tick();
        chk("fill_level_hold", level, 16);
        bus.k_stream_tready = 1'b1;
        #1;
        chk("fill_tready_full_pop", bus.lii_in_p0_tready, 1'b0);
        chk("fill_head0", bus.k_stream_tdata, 8'h00);
        tick();
        chk("fill_level15", level, 15);
        bus.k_stream_tready = 1'b0;
        #1;
        chk("fill_tready_free", bus.lii_in_p0_tready, 1'b1);
        chk("fill_head1", bus.k_stream_tdata, 8'h01);
        tick();
        chk("fill_level16b", level, 16);
        drive(1'b0, 8'h01, 8'h03, 64'h0);
        bus.k_stream_tready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            chk("fill_drain", bus.k_stream_tdata, 8'(j));
            tick();
        end
        chk("fill_level_end", level, 0);

        // ---- wrap-around: 40 flits, kernel ready toggles ----
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 40 && cyc < 400) begin
            bus.k_stream_tready = cyc[0];
            if (sent < 40) drive(1'b1, 8'h01, 8'h09, 64'(sent));
            else           drive(1'b0, 8'h01, 8'h09, 64'h0);
            #1;
            in_fire  = bus.lii_in_p0_tvalid & bus.lii_in_p0_tready;
            out_fire = bus.k_stream_tvalid & bus.k_stream_tready;
            if (out_fire) begin
                chk("wrap_data", bus.k_stream_tdata, 8'(rcvd));
                rcvd++;
            end
            if (in_fire) sent++;
            tick();
            cyc++;
        end
        drive(1'b0, 8'h01, 8'h09, 64'h0);
        chk("wrap_count", rcvd, 40);
        chk("wrap_level", level, 0);

        // ---- misroute while full ----
        bus.k_stream_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h01, 8'h04, 64'h80 + 64'(i));
            tick();
        end
        chk("mis_level_full", level, 16);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] dst;
            dst = (i == 1 || i == 3 || i == 5) ? 8'h02 : 8'h01;
            drive(1'b1, dst, 8'h04, (dst == 8'h02) ? 64'hEE : 64'h55);
            #1;
            chk("mis_tready", bus.lii_in_p0_tready, (dst == 8'h02) ? 1'b1 : 1'b0);
            tick();
        end
        drive(1'b0, 8'h01, 8'h04, 64'h0);
        chk("mis_drop3", drop_cnt, 3);
        chk("mis_level", level, 16);
        bus.k_stream_tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("mis_drain", bus.k_stream_tdata, 8'h80 + 8'(j));
            tick();
        end
        chk("mis_level_end", level, 0);
        chk("mis_kvalid_end", bus.k_stream_tvalid, 1'b0);

        // ---- drop counter saturation ----
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        chk("sat_preset", drop_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h02, 8'h04, 64'h33);
            tick();
            chk("sat_drop", drop_cnt, 16'hFFFF);
        end
        drive(1'b0, 8'h01, 8'h04, 64'h0);
        chk("sat_level", level, 0);

        // ---- truncation ----
        chk("trunc_pre", trunc_err, 1'b0);
        drive(1'b1, 8'h01, 8'h07, 64'h0000_0100_0000_00AB);
        tick();
        chk("trunc_data", bus.k_stream_tdata, 8'hAB);
        chk("trunc_src", bus.k_stream_src, 8'h07);
        chk("trunc_set", trunc_err, 1'b1);
        drive(1'b1, 8'h01, 8'h07, 64'h12);
        tick();
        chk("trunc_data2", bus.k_stream_tdata, 8'h12);
        chk("trunc_sticky", trunc_err, 1'b1);
        drive(1'b0, 8'h01, 8'h07, 64'h0);
        tick();
        chk("trunc_sticky2", trunc_err, 1'b1);
        chk("trunc_level", level, 0);

        // ---- reset mid-operation ----
        bus.k_stream_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'h01, 8'h06, 64'h60 + 64'(i));
            tick();
        end
        drive(1'b0, 8'h01, 8'h06, 64'h0);
        chk("mid_level7", level, 7);
        arstn = 1'b0;
        drive(1'b1, 8'h01, 8'h06, 64'h99);
        #1;
        chk("mid_rst_tready", bus.lii_in_p0_tready, 1'b0);
        tick();
        chk("mid_level0", level, 0);
        chk("mid_kvalid0", bus.k_stream_tvalid, 1'b0);
        chk("mid_drop0", drop_cnt, 0);
        chk("mid_trunc0", trunc_err, 1'b0);
        arstn = 1'b1;
        bus.k_stream_tready = 1'b1;
        drive(1'b1, 8'h01, 8'h06, 64'h5A);
        tick();
        drive(1'b0, 8'h01, 8'h06, 64'h0);
        chk("mid_kvalid1", bus.k_stream_tvalid, 1'b1);
        chk("mid_data", bus.k_stream_tdata, 8'h5A);
        chk("mid_level1", level, 1);
        tick();
        chk("mid_kvalid_end", bus.k_stream_tvalid, 1'b0);
        chk("mid_level_end", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
